// File: rtl/matrix_transpose_pkg.sv
// Shared types and helpers for the streaming matrix transpose wrapper.
package matrix_transpose_pkg;

    // Default element width; modules derive their own width-correct element
    // type from DATA_WIDTH and pass it down as a type parameter.
    localparam int ELEM_W_DFLT = 64;
    typedef logic [ELEM_W_DFLT-1:0] elem_t;

    typedef enum logic [2:0] {LOAD, KICK, WAIT, CAPT, DRAIN} mt_state_e;

    // Number of LANES-wide beats needed to move one NUM_MG x NUM_PE matrix.
    function automatic int beats(input int num_mg, input int num_pe, input int lanes);
        return (num_mg * num_pe) / lanes;
    endfunction

endpackage

// File: rtl/mt_beat_buffer.sv
// Element buffer with a LANES-wide beat write port, a whole-matrix load port,
// a LANES-wide beat read port and a flattened whole-matrix read port.
module mt_beat_buffer
    import matrix_transpose_pkg::*;
#(
    parameter type lane_t = elem_t,
    parameter int  DEPTH  = 16,
    parameter int  LANES  = 4,
    parameter int  AW     = 2
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic [AW-1:0]                     wr_beat,
    input  logic [LANES*$bits(lane_t)-1:0]    wr_data,
    input  logic                              ld_en,
    input  logic [DEPTH*$bits(lane_t)-1:0]    ld_data,
    input  logic [AW-1:0]                     rd_beat,
    output logic [LANES*$bits(lane_t)-1:0]    rd_data,
    output logic [DEPTH*$bits(lane_t)-1:0]    flat
);
    localparam int W = $bits(lane_t);

    // One register per element; each only listens to the beat that covers it.
    for (genvar e = 0; e < DEPTH; e++) begin : g_elem
        lane_t q;

        // Whole-matrix load takes priority over a beat write.
        always_ff @(posedge clk) begin
            if (ld_en)
                q <= ld_data[e*W +: W];
            else if (wr_en && wr_beat == AW'(e / LANES))
                q <= wr_data[(e % LANES)*W +: W];
        end

        assign flat[e*W +: W] = q;
    end

    // Beat b, lane k reads flat element b*LANES+k.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign rd_data[k*W +: W] = flat[(int'(rd_beat) * LANES + k) * W +: W];
    end

endmodule

// File: rtl/matrix_transpose_stream_wrapper.sv
// Streaming wrapper around the matrix transpose core: loads a matrix from a
// beat stream, launches the core, captures its result and drains it back out.
module matrix_transpose_stream_wrapper
    import matrix_transpose_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_MG         = 16,
    parameter int NUM_PE         = NUM_MG,
    parameter int LANES          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]         in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES*DATA_WIDTH-1:0]         out_data,
    output logic                                out_last,
    output logic                                busy,
    output logic                                timeout_err,
    output logic                                core_in_val,
    output logic [NUM_MG*NUM_PE*DATA_WIDTH-1:0] core_in,
    input  logic [NUM_MG*NUM_PE*DATA_WIDTH-1:0] core_out,
    input  logic                                core_out_val
);
    localparam int ELEMS = NUM_MG * NUM_PE;
    localparam int BEATS = beats(NUM_MG, NUM_PE, LANES);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WW    = $clog2(TIMEOUT_CYCLES);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [WW-1:0] WD_LOAD   = WW'(TIMEOUT_CYCLES - 1);

    typedef logic [DATA_WIDTH-1:0] lane_t;

    if (ELEMS % LANES != 0) begin : g_lanes_chk
        $error("NUM_MG*NUM_PE must be a multiple of LANES");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    mt_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WW-1:0] wd, wd_n;
    logic          err, err_n;

    logic                        in_wr;
    logic                        out_ld;
    logic [LANES*DATA_WIDTH-1:0] unused_in_rd;
    logic [ELEMS*DATA_WIDTH-1:0] unused_out_flat;

    assign in_wr  = (state == LOAD) && in_valid;
    assign out_ld = (state == WAIT) && core_out_val;

    // Input buffer: filled beat by beat, presented whole to the core.
    mt_beat_buffer #(
        .lane_t (lane_t),
        .DEPTH  (ELEMS),
        .LANES  (LANES),
        .AW     (CW)
    ) u_in_buf (
        .clk     (clk),
        .wr_en   (in_wr),
        .wr_beat (cnt),
        .wr_data (in_data),
        .ld_en   (1'b0),
        .ld_data ('0),
        .rd_beat (cnt),
        .rd_data (unused_in_rd),
        .flat    (core_in)
    );

    // Output buffer: captured whole from the core, drained beat by beat.
    mt_beat_buffer #(
        .lane_t (lane_t),
        .DEPTH  (ELEMS),
        .LANES  (LANES),
        .AW     (CW)
    ) u_out_buf (
        .clk     (clk),
        .wr_en   (1'b0),
        .wr_beat (cnt),
        .wr_data ('0),
        .ld_en   (out_ld),
        .ld_data (core_out),
        .rd_beat (cnt),
        .rd_data (out_data),
        .flat    (unused_out_flat)
    );

    // Control state, beat counter, watchdog and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            cnt   <= '0;
            wd    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wd    <= wd_n;
            err   <= err_n;
        end
    end

    // Next-state logic; a result on the watchdog's last cycle still counts.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wd_n    = wd;
        err_n   = err;
        case (state)
            LOAD: begin
                if (in_valid) begin
                    if (cnt == LAST_BEAT) begin
                        state_n = KICK;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            KICK: begin
                wd_n    = WD_LOAD;
                state_n = WAIT;
            end
            WAIT: begin
                if (core_out_val) begin
                    state_n = CAPT;
                end else if (wd == '0) begin
                    err_n   = 1'b1;
                    state_n = LOAD;
                    cnt_n   = '0;
                end else begin
                    wd_n = wd - 1'b1;
                end
            end
            CAPT: begin
                state_n = DRAIN;
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt == LAST_BEAT) begin
                        state_n = LOAD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = LOAD;
                cnt_n   = '0;
            end
        endcase
    end

    assign in_ready    = (state == LOAD);
    assign core_in_val = (state == KICK);
    assign out_valid   = (state == DRAIN);
    assign out_last    = (state == DRAIN) && (cnt == LAST_BEAT);
    assign busy        = !((state == LOAD) && (cnt == '0));
    assign timeout_err = err;

endmodule

// File: tb/tb_matrix_transpose_stream_wrapper.sv
// Scoreboard bench for matrix_transpose_stream_wrapper with a behavioural
// transpose core that answers a programmable number of cycles after launch.
module tb_matrix_transpose_stream_wrapper;
    localparam int DW    = 16;
    localparam int NM    = 4;
    localparam int NP    = 4;
    localparam int LN    = 2;
    localparam int TO    = 8;
    localparam int BEATS = NM * NP / LN;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [LN*DW-1:0]       in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LN*DW-1:0]       out_data;
    logic                   out_last;
    logic                   busy;
    logic                   timeout_err;
    logic                   core_in_val;
    logic [NM*NP*DW-1:0]    core_in;
    logic [NM*NP*DW-1:0]    core_out = '0;
    logic                   core_out_val = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [LN*DW-1:0] data;
        logic             last;
    } exp_t;
    exp_t sb[$];

    int core_en  = 1;
    int core_dly = 3;
    int cd       = 0;
    int kick_cnt = 0;

    always #5 clk = ~clk;

    matrix_transpose_stream_wrapper #(
        .DATA_WIDTH     (DW),
        .NUM_MG         (NM),
        .NUM_PE         (NP),
        .LANES          (LN),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .core_in_val  (core_in_val),
        .core_in      (core_in),
        .core_out     (core_out),
        .core_out_val (core_out_val)
    );

    // Core model: answers core_dly cycles after the launch pulse with the transpose.
    always @(negedge clk) begin
        core_out_val = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                for (int r = 0; r < NM; r++)
                    for (int c = 0; c < NP; c++)
                        core_out[(r*NP+c)*DW +: DW] = core_in[(c*NP+r)*DW +: DW];
                core_out_val = 1'b1;
            end
        end
        if (core_in_val === 1'b1) begin
            kick_cnt++;
            if (core_en != 0) cd = core_dly;
        end
    end

    // Streams a matrix whose element e holds base+e; ends on the KICK cycle.
    task automatic load_matrix(input int base, input bit gaps, input bit push);
        int b = 0;
        int cyc = 0;
        logic [LN*DW-1:0] d;
        exp_t x;
        while (b < BEATS && cyc < 200) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < LN; k++) d[k*DW +: DW] = DW'(base + b*LN + k);
            in_data  = d;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_valid && in_ready) b++;
        end
        checks++;
        if (b < BEATS) begin
            errors++;
            $display("FAIL load_timeout beats=%0d want=%0d", b, BEATS);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (core_in_val !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL kick core_in_val=%b in_ready=%b want 1/0", core_in_val, in_ready);
        end
        if (push) begin
            for (int bb = 0; bb < BEATS; bb++) begin
                for (int k = 0; k < LN; k++) begin
                    int e = bb*LN + k;
                    x.data[k*DW +: DW] = DW'(base + (e % NP) * NP + (e / NP));
                end
                x.last = (bb == BEATS - 1);
                sb.push_back(x);
            end
        end
    endtask

    // Collects up to stop_after output beats; mode 1 toggles out_ready 1010...
    task automatic drain(input int mode, input int stop_after, input bit chk_block);
        int hs = 0;
        int cyc = 0;
        bit stalled = 0;
        bit block_bad = 0;
        logic [LN*DW-1:0] held;
        exp_t x;
        while (hs < stop_after && cyc < 300) begin
            @(negedge clk);
            cyc++;
            out_ready = (mode == 1) ? 1'(cyc % 2) : 1'b1;
            #1;
            if (in_ready !== 1'b0) block_bad = 1;
            if (out_valid === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL stall_hold data=%h want=%h", out_data, held);
                    end
                end
                if (out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat data=%h want none", out_data);
                    end else begin
                        x = sb.pop_front();
                        if (out_data !== x.data || out_last !== x.last) begin
                            errors++;
                            $display("FAIL beat%0d data=%h last=%b want %h/%b",
                                     hs, out_data, out_last, x.data, x.last);
                        end
                    end
                    hs++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held    = out_data;
                end
            end
        end
        checks++;
        if (hs != stop_after) begin
            errors++;
            $display("FAIL handshakes got=%0d want=%0d", hs, stop_after);
        end
        if (chk_block) begin
            checks++;
            if (block_bad) begin
                errors++;
                $display("FAIL in_ready_block got=1 want=0 before last handshake");
            end
        end
        if (stop_after == BEATS) begin
            @(negedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || sb.size() != 0) begin
                errors++;
                $display("FAIL post_drain in_ready=%b out_valid=%b left=%0d want 1/0/0",
                         in_ready, out_valid, sb.size());
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b want=0", out_last); end
        checks++;
        if (core_in_val !== 1'b0) begin errors++; $display("FAIL rst_core_in_val got=%b want=0", core_in_val); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got=%b want=0", timeout_err); end
    endtask

    task automatic test_basic();
        int k0 = kick_cnt;
        load_matrix(0, 0, 1);
        drain(0, BEATS, 1);
        checks++;
        if (kick_cnt != k0 + 1) begin
            errors++;
            $display("FAIL kick_count got=%0d want=%0d", kick_cnt - k0, 1);
        end
    endtask

    task automatic test_backpressure();
        load_matrix(100, 0, 1);
        drain(1, BEATS, 1);
        out_ready = 1'b1;
    endtask

    task automatic test_gaps();
        load_matrix(200, 1, 1);
        drain(0, BEATS, 1);
    endtask

    task automatic test_race();
        core_dly = TO;
        load_matrix(300, 0, 1);
        drain(0, BEATS, 1);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL race_err got=%b want=0", timeout_err);
        end
        core_dly = 3;
    endtask

    task automatic test_timeout();
        core_en = 0;
        load_matrix(400, 0, 0);
        repeat (TO) @(negedge clk);
        #1;
        checks++;
        if (timeout_err !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early err=%b in_ready=%b want 0/0", timeout_err, in_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (timeout_err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit err=%b in_ready=%b busy=%b want 1/1/0",
                     timeout_err, in_ready, busy);
        end
        core_en = 1;
        load_matrix(500, 0, 1);
        drain(0, BEATS, 1);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky got=%b want=1", timeout_err);
        end
    endtask

    task automatic test_mid_reset();
        load_matrix(600, 0, 1);
        drain(0, 4, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset out_valid=%b busy=%b in_ready=%b err=%b want 0/0/1/0",
                     out_valid, busy, in_ready, timeout_err);
        end
        sb.delete();
        load_matrix(700, 0, 1);
        drain(0, BEATS, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_race();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
